// File: rtl/enc_pkg.sv
// Shared RV32I encoding definitions: mnemonic codes, opcodes, the per-mnemonic
// field table, and the canonical NOP word.
package enc_pkg;

    localparam logic [4:0] M_LUI   = 5'd0;
    localparam logic [4:0] M_ADD   = 5'd1;
    localparam logic [4:0] M_SUB   = 5'd2;
    localparam logic [4:0] M_OR    = 5'd3;
    localparam logic [4:0] M_AND   = 5'd4;
    localparam logic [4:0] M_XOR   = 5'd5;
    localparam logic [4:0] M_SLL   = 5'd6;
    localparam logic [4:0] M_SRL   = 5'd7;
    localparam logic [4:0] M_SRA   = 5'd8;
    localparam logic [4:0] M_SLT   = 5'd9;
    localparam logic [4:0] M_SLTU  = 5'd10;
    localparam logic [4:0] M_LW    = 5'd11;
    localparam logic [4:0] M_ADDI  = 5'd12;
    localparam logic [4:0] M_ANDI  = 5'd13;
    localparam logic [4:0] M_ORI   = 5'd14;
    localparam logic [4:0] M_XORI  = 5'd15;
    localparam logic [4:0] M_SLTI  = 5'd16;
    localparam logic [4:0] M_SLTIU = 5'd17;
    localparam logic [4:0] M_SLLI  = 5'd18;
    localparam logic [4:0] M_SRLI  = 5'd19;
    localparam logic [4:0] M_SRAI  = 5'd20;
    localparam logic [4:0] M_SW    = 5'd21;
    localparam logic [4:0] M_BEQ   = 5'd22;
    localparam logic [4:0] M_BNE   = 5'd23;
    localparam logic [4:0] M_BLT   = 5'd24;
    localparam logic [4:0] M_BGE   = 5'd25;
    localparam logic [4:0] M_BLTU  = 5'd26;
    localparam logic [4:0] M_BGEU  = 5'd27;
    localparam logic [4:0] M_JAL   = 5'd28;
    localparam logic [4:0] M_JALR  = 5'd29;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
    } enc_info_t;

    function automatic enc_info_t mnem_info(input logic [4:0] m);
        enc_info_t info;
        info = '{FMT_BAD, OP_IMM, 3'b000, F7_BASE};
        case (m)
            M_LUI:   info = '{FMT_U,  OP_LUI,    3'b000, F7_BASE};
            M_ADD:   info = '{FMT_R,  OP_OP,     3'b000, F7_BASE};
            M_SUB:   info = '{FMT_R,  OP_OP,     3'b000, F7_ALT};
            M_OR:    info = '{FMT_R,  OP_OP,     3'b110, F7_BASE};
            M_AND:   info = '{FMT_R,  OP_OP,     3'b111, F7_BASE};
            M_XOR:   info = '{FMT_R,  OP_OP,     3'b100, F7_BASE};
            M_SLL:   info = '{FMT_R,  OP_OP,     3'b001, F7_BASE};
            M_SRL:   info = '{FMT_R,  OP_OP,     3'b101, F7_BASE};
            M_SRA:   info = '{FMT_R,  OP_OP,     3'b101, F7_ALT};
            M_SLT:   info = '{FMT_R,  OP_OP,     3'b010, F7_BASE};
            M_SLTU:  info = '{FMT_R,  OP_OP,     3'b011, F7_BASE};
            M_LW:    info = '{FMT_I,  OP_LOAD,   3'b010, F7_BASE};
            M_ADDI:  info = '{FMT_I,  OP_IMM,    3'b000, F7_BASE};
            M_ANDI:  info = '{FMT_I,  OP_IMM,    3'b111, F7_BASE};
            M_ORI:   info = '{FMT_I,  OP_IMM,    3'b110, F7_BASE};
            M_XORI:  info = '{FMT_I,  OP_IMM,    3'b100, F7_BASE};
            M_SLTI:  info = '{FMT_I,  OP_IMM,    3'b010, F7_BASE};
            M_SLTIU: info = '{FMT_I,  OP_IMM,    3'b011, F7_BASE};
            M_SLLI:  info = '{FMT_SH, OP_IMM,    3'b001, F7_BASE};
            M_SRLI:  info = '{FMT_SH, OP_IMM,    3'b101, F7_BASE};
            M_SRAI:  info = '{FMT_SH, OP_IMM,    3'b101, F7_ALT};
            M_SW:    info = '{FMT_S,  OP_STORE,  3'b010, F7_BASE};
            M_BEQ:   info = '{FMT_B,  OP_BRANCH, 3'b000, F7_BASE};
            M_BNE:   info = '{FMT_B,  OP_BRANCH, 3'b001, F7_BASE};
            M_BLT:   info = '{FMT_B,  OP_BRANCH, 3'b100, F7_BASE};
            M_BGE:   info = '{FMT_B,  OP_BRANCH, 3'b101, F7_BASE};
            M_BLTU:  info = '{FMT_B,  OP_BRANCH, 3'b110, F7_BASE};
            M_BGEU:  info = '{FMT_B,  OP_BRANCH, 3'b111, F7_BASE};
            M_JAL:   info = '{FMT_J,  OP_JAL,    3'b000, F7_BASE};
            M_JALR:  info = '{FMT_I,  OP_JALR,   3'b000, F7_BASE};
            default: info = '{FMT_BAD, OP_IMM,   3'b000, F7_BASE};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rv32i_word_pack.sv
// Combinational packer: symbolic instruction fields -> 32-bit RV32I word.
// illegal flags both an unknown mnemonic and an odd B/J byte offset.
module rv32i_word_pack
    import enc_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    enc_info_t info;

    // Immediate bits above the widest field (J, bit 20) are silently truncated.
    logic unused_imm;
    assign unused_imm = ^imm[31:21];

    // NOTE: word and illegal get defaults before the case so no path infers a latch.
    always_comb begin
        info    = mnem_info(mnem);
        word    = NOP;
        illegal = 1'b0;
        case (info.fmt)
            FMT_R:  word = {info.f7, rs2, rs1, info.f3, rd, info.opcode};
            FMT_I:  word = {imm[11:0], rs1, info.f3, rd, info.opcode};
            FMT_SH: word = {info.f7, imm[4:0], rs1, info.f3, rd, info.opcode};
            FMT_S:  word = {imm[11:5], rs2, rs1, info.f3, imm[4:0], info.opcode};
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, info.f3,
                           imm[4:1], imm[11], info.opcode};
                illegal = imm[0];
            end
            FMT_U:  word = {imm[19:0], rd, info.opcode};
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info.opcode};
                illegal = imm[0];
            end
            default: begin
                word    = NOP;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: one symbolic instruction per handshake in, one
// machine word plus wrapping instruction-memory word address out.
module rv32i_instr_encoder
    import enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    logic [31:0]       packed_word;
    logic              packed_illegal;
    logic              in_fire;
    logic              out_fire;
    logic [ADDR_W-1:0] next_addr;

    rv32i_word_pack u_pack (
        .mnem    (in_mnem),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // Flush closes the input so nothing slips in while state is being cleared.
    assign in_ready  = (!out_valid || out_ready) && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign next_addr = (out_addr == LAST_ADDR) ? FIRST_ADDR : out_addr + 1'b1;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= FIRST_ADDR;
            err       <= 1'b0;
            count     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_addr  <= FIRST_ADDR;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            if (out_fire) begin
                out_addr <= next_addr;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
            if (in_fire) begin
                out_word  <= packed_word;
                out_valid <= 1'b1;
                if (packed_illegal) begin
                    err <= 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: the driver queues the expected
// word/address on each accept, a monitor pops and compares on each write.
module tb_rv32i_instr_encoder;
    import enc_pkg::*;

    localparam int AW   = 3;
    localparam int DEP  = 4;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_mnem, in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [AW:0]   count;

    typedef struct {
        logic [31:0]   word;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   exp_addr = BASE;
    int   n_checks = 0;
    int   n_errors = 0;

    rv32i_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEP)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every memory-side write must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got 0x%08h at addr %0d with nothing queued",
                             out_word, out_addr);
                end else begin
                    e = sb.pop_front();
                    check("word", out_word, e.word);
                    check("addr", 32'(out_addr), 32'(e.addr));
                end
            end
        end
    end

    task automatic send(input logic [4:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_w, output int waits);
        in_mnem  = m;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
        end else begin
            sb.push_back('{exp_w, AW'(exp_addr)});
            exp_addr = (exp_addr == BASE + DEP - 1) ? BASE : exp_addr + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Flush with a request presented, proving the input is closed during flush.
    task automatic do_flush();
        flush    = 1'b1;
        in_mnem  = M_ADDI;
        in_rd    = 5'd9;
        in_rs1   = 5'd0;
        in_rs2   = 5'd0;
        in_imm   = 32'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_addr = BASE;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_addr", 32'(out_addr), 32'(BASE));
        check("flush_count", 32'(count), 32'd0);
        check("flush_err", 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mnem = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'(BASE));
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single R-type word.
        send(M_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, w1);
        drain();
        check("count_after_add", 32'(count), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back, no bubble.
        send(M_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, w1);
        send(M_SRAI, 5'd3, 5'd1, 5'd0, 32'd4, 32'h4040D193, w2);
        check("no_bubble_waits", 32'(w1 + w2), 32'd0);
        drain();
        check("count_after_pair", 32'(count), 32'd3);

        // Remaining formats; JAL lands on the wrapped address.
        send(M_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, w1);
        send(M_JAL,  5'd1, 5'd0, 5'd0, 32'd16,       32'h010000EF, w1);
        send(M_SW,   5'd0, 5'd1, 5'd2, 32'd4,        32'h0020A223, w1);
        send(M_LUI,  5'd5, 5'd0, 5'd0, 32'h12345,    32'h123452B7, w1);
        send(M_SLLI, 5'd2, 5'd2, 5'd0, 32'h25,       32'h00511113, w1);
        drain();
        check("count_after_formats", 32'(count), 32'd8);

        // Backpressure: held word stays put and the next request waits.
        out_ready = 1'b0;
        send(M_ADD, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00628233, w1);
        in_mnem = M_SUB; in_rd = 5'd7; in_rs1 = 5'd8; in_rs2 = 5'd9; in_imm = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_word", out_word, 32'h00628233);
            check("bp_out_addr", 32'(out_addr), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(M_SUB, 5'd7, 5'd8, 5'd9, 32'd0, 32'h409403B3, w1);
        drain();
        check("count_after_bp", 32'(count), 32'd10);

        // Illegal mnemonic emits NOP, err is sticky.
        send(5'd31, 5'd1, 5'd1, 5'd1, 32'd0, NOP, w1);
        drain();
        check("err_illegal", 32'(err), 32'd1);
        send(M_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, w1);
        drain();
        check("err_sticky", 32'(err), 32'd1);
        check("count_after_illegal", 32'(count), 32'd12);

        do_flush();

        // Misaligned branch: offset 7 encodes as 6 and raises err.
        send(M_BNE, 5'd0, 5'd1, 5'd2, 32'd7, 32'h00209363, w1);
        drain();
        check("err_misaligned", 32'(err), 32'd1);
        do_flush();

        // Held word dropped by flush: the monitor flags it if it ever appears.
        out_ready = 1'b0;
        send(M_XOR, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003140B3, w1);
        out_ready = 1'b1;
        do_flush();
        repeat (3) @(posedge clk);
        #1;

        // Address wrap over DEPTH=4, then count saturation at all-ones.
        for (int i = 0; i < 5; i++)
            send(M_ADDI, 5'd1, 5'd0, 5'd0, 32'(i), 32'h00000093 | (32'(i) << 20), w1);
        drain();
        check("count_after_wrap", 32'(count), 32'd5);
        for (int i = 0; i < 12; i++)
            send(M_ADDI, 5'd1, 5'd0, 5'd0, 32'(i), 32'h00000093 | (32'(i) << 20), w1);
        drain();
        check("count_saturated", 32'(count), 32'd15);

        // Asynchronous reset with a held word discards it immediately.
        out_ready = 1'b0;
        send(M_ORI, 5'd2, 5'd3, 5'd0, 32'h7FF, 32'h7FF1E113, w1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_word", out_word, 32'd0);
        check("arst_out_addr", 32'(out_addr), 32'(BASE));
        check("arst_count", 32'(count), 32'd0);
        sb.delete();
        exp_addr = BASE;
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(M_JALR, 5'd1, 5'd2, 5'd0, 32'h10, 32'h010100E7, w1);
        drain();
        check("count_after_reset", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the control decoder. It accepts one symbolic instruction per handshake (mnemonic code, register indices, immediate) and produces the 32-bit machine word. Each word is paired with an incrementing instruction-memory word address. It sits on the simulator's program-load path, between the testbench/loader and the instruction memory write port.

Parameters:
ADDR_W, 10, instruction-memory word-address width
BASE_ADDR, 0, first word address after reset/flush
DEPTH, 1024, number of words; address wraps to BASE_ADDR after BASE_ADDR+DEPTH-1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  sync: drop held output, address back to BASE_ADDR, clear err
in_valid  in  1  request valid
in_ready  out  1  encoder can accept
in_mnem  in  5  mnemonic code (enc_pkg)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  immediate: byte offset for B/J; upper 20 bits in [19:0] for LUI; shamt in [4:0] for shifts
out_valid  out  1  encoded word valid
out_ready  in  1  memory side accepts
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  word address for out_word
err  out  1  sticky: illegal mnemonic or misaligned B/J offset
count  out  ADDR_W+1  words emitted since reset/flush, saturating

Behaviour:
- Reset (rstn low, async): out_valid=0, out_word=0, out_addr=BASE_ADDR, err=0, count=0.
- in_ready = !out_valid | out_ready, combinational. Full throughput: one word per cycle when out_ready is held high.
- Latency: an accepted request appears on out_word/out_valid on the next clock edge.
- Output register is stable while out_valid & !out_ready; no request is accepted in that state.
- Output handshake (out_valid & out_ready): out_addr increments, wrapping as defined; count increments and saturates at all-ones.
- Simultaneous output and input handshake in the same cycle: new word loaded, address advances once.
- Encoding per format:
  - R: funct7|rs2|rs1|f3|rd|0110011.
  - I-ALU/LW/JALR: imm[11:0]|rs1|f3|rd|op.
  - Shifts: f7|shamt[4:0]|rs1|f3|rd|0010011.
  - S: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - U: imm[19:0]|rd|0110111.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused fields are forced to zero. Upper immediate bits beyond the field are ignored (truncated, no error).
- Illegal mnemonic (code >= 30): emit NOP 0x00000013 and set err.
- B/J with in_imm[0]=1: encode with imm[0] dropped and set err.
- flush: highest priority over handshakes. Next cycle out_valid=0, out_addr=BASE_ADDR, count=0, err=0; in_ready is forced low during the flush cycle.
- Reset mid-stream: held word is discarded with no write issued.

Decomposition:
- enc_pkg:
  - mnemonic localparams 0..29: LUI, ADD, SUB, OR, AND, XOR, SLL, SRL, SRA, SLT, SLTU, LW, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR;
  - opcode constants shared with the control decoder's encode definitions;
  - NOP constant.
- One combinational sub-module, rv32i_word_pack: mnemonic + fields -> {word, illegal}.
- Top level holds the handshake, output register, address and count logic.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, out_ready=1 -> out_word 0x002081B3 at out_addr 0 one cycle later; count=1.
- ADDI rd=1 rs1=0 imm=5, then SRAI rd=3 rs1=1 imm=4 back-to-back -> 0x00500093 @0, 0x4040D193 @1; no bubble.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. JAL rd=1 imm=16 -> 0x010000EF. SW rs1=1 rs2=2 imm=4 -> 0x0020A223. LUI rd=5 imm=0x12345 -> 0x123452B7.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_word/out_addr held. Release -> next word at address+1, no loss or duplication.
- Mnemonic 31 -> 0x00000013 and err=1 (sticky). BNE imm=7 -> offset-6 encoding and err=1. flush -> err=0, out_addr=0, out_valid=0.
- DEPTH=4: emit 5 words -> addresses 0,1,2,3,0; count=5. Assert rstn low while out_valid=1 -> out_valid=0 immediately.
